// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types for the sequential ALU slice.
//   - op_e    : 4-bit opcode encoding (codes 12-15 are unassigned and
//               execute as PASS)
//   - state_e : controller states
//   - is_multi: true for the opcodes that run in the multi-cycle shifter
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_PASS = 4'd0,
        OP_ADD  = 4'd1,
        OP_ADC  = 4'd2,
        OP_SUB  = 4'd3,
        OP_SBC  = 4'd4,
        OP_NAND = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_RCL  = 4'd8,
        OP_RCR  = 4'd9,
        OP_SHLN = 4'd10,
        OP_SHRN = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_SHLN) || (op == OP_SHRN);
    endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Purely combinational single-step ALU. SHLN/SHRN evaluate to a single
//   one-bit shift; the sequencer repeats them to build an N-bit shift.
//   Ports:
//     op   [3:0]        opcode (alu_pkg::op_e encoding)
//     a, b [WIDTH-1:0]  operands
//     cin               carry in (ADC/SBC/RCL/RCR)
//     r    [WIDTH-1:0]  result
//     cout              carry out (1 = no borrow for SUB/SBC)
//     lt                result MSB
//     z                 result is zero
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             lt,
    output logic             z
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] cin_ext;

    always_comb begin
        sum     = '0;
        cin_ext = {{WIDTH{1'b0}}, cin};
        r       = a;
        cout    = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                sum       = {1'b0, a} + {1'b0, b};
                {cout, r} = sum;
            end
            OP_ADC: begin
                sum       = {1'b0, a} + {1'b0, b} + cin_ext;
                {cout, r} = sum;
            end
            OP_SUB: begin
                sum       = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                {cout, r} = sum;
            end
            OP_SBC: begin
                sum       = {1'b0, a} + {1'b0, ~b} + cin_ext;
                {cout, r} = sum;
            end
            OP_NAND: begin
                r = ~(a & b);
            end
            OP_SHL, OP_SHLN: begin
                r    = {a[WIDTH-2:0], 1'b0};
                cout = a[WIDTH-1];
            end
            OP_SHR, OP_SHRN: begin
                r    = {1'b0, a[WIDTH-1:1]};
                cout = a[0];
            end
            OP_RCL: begin
                r    = {a[WIDTH-2:0], cin};
                cout = a[WIDTH-1];
            end
            OP_RCR: begin
                r    = {cin, a[WIDTH-1:1]};
                cout = a[0];
            end
            default: begin
                r    = a;
                cout = 1'b0;
            end
        endcase
    end

    assign lt = r[WIDTH-1];
    assign z  = (r == '0);

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Sequential ALU: single-cycle ops finish one cycle after start, SHLN/SHRN
//   shift one bit per cycle for b[CW-1:0] cycles (one idle SHIFT cycle for a
//   count of zero). Result and flags are loaded on entry to DONE so they are
//   already valid while done is high.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     start, op, a, b, fl_we   request and operands (sampled in IDLE only)
//     busy                     high while shifting
//     done                     one-cycle completion pulse
//     o                        registered result
//     fl_carry, fl_lt, fl_z    registered flags (updated only if fl_we)
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             fl_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             fl_carry,
    output logic             fl_lt,
    output logic             fl_z
);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             fc_q, fc_d;
    logic             flt_q, flt_d;
    logic             fz_q, fz_d;

    logic [3:0]       core_op;
    logic [WIDTH-1:0] core_a;
    logic             core_cin;
    logic [WIDTH-1:0] core_r;
    logic             core_cout, core_lt, core_z;

    // The core is shared: it evaluates the live request in IDLE and the
    // captured shift step in SHIFT.
    assign core_op  = (state_q == ST_SHIFT) ? op_q   : op;
    assign core_a   = (state_q == ST_SHIFT) ? work_q : a;
    assign core_cin = (state_q == ST_SHIFT) ? c_q    : fc_q;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op   (core_op),
        .a    (core_a),
        .b    (b),
        .cin  (core_cin),
        .r    (core_r),
        .cout (core_cout),
        .lt   (core_lt),
        .z    (core_z)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        we_d    = we_q;
        work_d  = work_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        fc_d    = fc_q;
        flt_d   = flt_q;
        fz_d    = fz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = op;
                    we_d = fl_we;
                    if (is_multi(op)) begin
                        work_d  = a;
                        cnt_d   = b[CW-1:0];
                        c_d     = fc_q;
                        state_d = ST_SHIFT;
                    end else begin
                        o_d = core_r;
                        if (fl_we) begin
                            fc_d  = core_cout;
                            flt_d = core_lt;
                            fz_d  = core_z;
                        end
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    // Zero count: no shift, carry keeps the value seen at start.
                    o_d = work_q;
                    if (we_q) begin
                        fc_d  = c_q;
                        flt_d = work_q[WIDTH-1];
                        fz_d  = (work_q == '0);
                    end
                    state_d = ST_DONE;
                end else begin
                    work_d = core_r;
                    c_d    = core_cout;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        o_d = core_r;
                        if (we_q) begin
                            fc_d  = core_cout;
                            flt_d = core_lt;
                            fz_d  = core_z;
                        end
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            we_q    <= 1'b0;
            work_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            o_q     <= '0;
            fc_q    <= 1'b0;
            flt_q   <= 1'b0;
            fz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            we_q    <= we_d;
            work_q  <= work_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            fc_q    <= fc_d;
            flt_q   <= flt_d;
            fz_q    <= fz_d;
        end
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign o        = o_q;
    assign fl_carry = fc_q;
    assign fl_lt    = flt_q;
    assign fl_z     = fz_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
//   Bench for alu_seq: an 8-bit instance driven from a vector table and a
//   16-bit instance for the wide rotate/zero-count sequence. Expected results
//   are queued when a request is driven and popped when done appears.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s8, s16;
    logic [3:0]  op8, op16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        we8, we16;
    logic        busy8, done8, fc8, flt8, fz8;
    logic        busy16, done16, fc16, flt16, fz16;
    logic [7:0]  o8;
    logic [15:0] o16;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .op(op8), .a(a8), .b(b8), .fl_we(we8),
        .busy(busy8), .done(done8), .o(o8),
        .fl_carry(fc8), .fl_lt(flt8), .fl_z(fz8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16), .op(op16), .a(a16), .b(b16), .fl_we(we16),
        .busy(busy16), .done(done16), .o(o16),
        .fl_carry(fc16), .fl_lt(flt16), .fl_z(fz16)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        we;
        logic [15:0] eo;
        logic        ec, el, ez;
        int          lat;
        bit          noise;
    } vec_t;

    typedef struct {
        logic [15:0] o;
        logic [2:0]  fl;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[21];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] cur_o(input bit sel);
        return sel ? o16 : {8'h00, o8};
    endfunction

    function automatic logic [2:0] cur_fl(input bit sel);
        return sel ? {fc16, flt16, fz16} : {fc8, flt8, fz8};
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy16 : busy8;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? done16 : done8;
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic we);
        if (sel) begin
            s16 = st; op16 = op; a16 = a; b16 = b; we16 = we;
        end else begin
            s8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; we8 = we;
        end
    endtask

    // Issue one request, wait (bounded) for done, then compare against the
    // scoreboard entry. With noise set, start stays asserted with junk
    // operands throughout busy and DONE; none of it may be accepted.
    task automatic run(input bit sel, input string name, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic we,
                       input logic [15:0] eo, input logic ec, input logic el,
                       input logic ez, input int lat, input bit noise);
        exp_t e;
        int   cyc;
        int   bc;
        e.o   = eo;
        e.fl  = {ec, el, ez};
        e.lat = lat;
        sb.push_back(e);
        drive(sel, 1'b1, op, a, b, we);
        @(posedge clk); #1;
        drive(sel, noise, 4'h1, 16'h0000, 16'h0000, 1'b1);
        cyc = 1;
        bc  = 0;
        while (!cur_done(sel) && cyc < 40) begin
            if (cur_busy(sel)) bc++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_done_seen"}, {31'd0, cur_done(sel)}, 32'd1);
        e = sb.pop_front();
        if (cur_done(sel)) begin
            chk({name, "_o"}, {16'd0, cur_o(sel)}, {16'd0, e.o});
            chk({name, "_flags"}, {29'd0, cur_fl(sel)}, {29'd0, e.fl});
            chk({name, "_latency"}, cyc, e.lat);
            chk({name, "_busy_cycles"}, bc, e.lat - 1);
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
        chk({name, "_idle_after"}, {30'd0, cur_busy(sel), cur_done(sel)}, 32'd0);
    endtask

    function automatic vec_t v(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic we, input logic [15:0] eo, input logic ec,
                               input logic el, input logic ez, input int lat, input bit noise);
        vec_t r;
        r.op = op; r.a = a; r.b = b; r.we = we; r.eo = eo;
        r.ec = ec; r.el = el; r.ez = ez; r.lat = lat; r.noise = noise;
        return r;
    endfunction

    initial begin : main
        bit seen_done;

        //                 op     a      b     we  o     c     lt    z   lat noise
        vecs[0]  = v(4'd3,  16'h05, 16'h05, 1, 16'h00, 1'b1, 1'b0, 1'b1, 1, 0);
        vecs[1]  = v(4'd1,  16'hFF, 16'h01, 1, 16'h00, 1'b1, 1'b0, 1'b1, 1, 0);
        vecs[2]  = v(4'd2,  16'h00, 16'h00, 1, 16'h01, 1'b0, 1'b0, 1'b0, 1, 0);
        vecs[3]  = v(4'd4,  16'h10, 16'h01, 1, 16'h0E, 1'b1, 1'b0, 1'b0, 1, 0);
        vecs[4]  = v(4'd4,  16'h10, 16'h01, 1, 16'h0F, 1'b1, 1'b0, 1'b0, 1, 0);
        vecs[5]  = v(4'd3,  16'h01, 16'h02, 1, 16'hFF, 1'b0, 1'b1, 1'b0, 1, 0);
        vecs[6]  = v(4'd8,  16'h80, 16'h00, 1, 16'h00, 1'b1, 1'b0, 1'b1, 1, 0);
        vecs[7]  = v(4'd8,  16'h40, 16'h00, 1, 16'h81, 1'b0, 1'b1, 1'b0, 1, 0);
        vecs[8]  = v(4'd9,  16'h01, 16'h00, 1, 16'h00, 1'b1, 1'b0, 1'b1, 1, 0);
        vecs[9]  = v(4'd6,  16'hC3, 16'h00, 1, 16'h86, 1'b1, 1'b1, 1'b0, 1, 0);
        vecs[10] = v(4'd7,  16'hC3, 16'h00, 1, 16'h61, 1'b1, 1'b0, 1'b0, 1, 0);
        vecs[11] = v(4'd5,  16'hF0, 16'h3C, 1, 16'hCF, 1'b0, 1'b1, 1'b0, 1, 0);
        vecs[12] = v(4'd0,  16'h7F, 16'h11, 1, 16'h7F, 1'b0, 1'b0, 1'b0, 1, 0);
        vecs[13] = v(4'd13, 16'h80, 16'h22, 1, 16'h80, 1'b0, 1'b1, 1'b0, 1, 0);
        vecs[14] = v(4'd11, 16'h81, 16'h03, 1, 16'h10, 1'b0, 1'b0, 1'b0, 4, 1);
        vecs[15] = v(4'd10, 16'h01, 16'h07, 1, 16'h80, 1'b0, 1'b1, 1'b0, 8, 0);
        vecs[16] = v(4'd10, 16'h03, 16'h0F, 1, 16'h80, 1'b1, 1'b1, 1'b0, 8, 0);
        vecs[17] = v(4'd11, 16'h55, 16'h00, 1, 16'h55, 1'b1, 1'b0, 1'b0, 2, 0);
        vecs[18] = v(4'd5,  16'hFF, 16'hFF, 0, 16'h00, 1'b1, 1'b0, 1'b0, 1, 0);
        vecs[19] = v(4'd1,  16'h01, 16'h01, 0, 16'h02, 1'b1, 1'b0, 1'b0, 1, 0);
        vecs[20] = v(4'd2,  16'h00, 16'h00, 1, 16'h01, 1'b0, 1'b0, 1'b0, 1, 0);

        rst = 1'b1;
        drive(0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst8_o", {24'd0, o8}, 32'd0);
        chk("rst8_flags", {29'd0, cur_fl(0)}, 32'd0);
        chk("rst8_ctrl", {30'd0, busy8, done8}, 32'd0);
        chk("rst16_o", {16'd0, o16}, 32'd0);
        chk("rst16_ctrl", {29'd0, busy16, done16, fc16}, 32'd0);
        rst = 1'b0;

        for (int unsigned i = 0; i < 21; i++) begin
            run(0, $sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].we,
                vecs[i].eo, vecs[i].ec, vecs[i].el, vecs[i].ez, vecs[i].lat, vecs[i].noise);
        end

        // Wide instance: zero-count shift keeps prior carry, then rotate in it.
        run(1, "w16_add",   4'd1,  16'hFFFF, 16'h0001, 1, 16'h0000, 1'b1, 1'b0, 1'b1, 1, 0);
        run(1, "w16_shln0", 4'd10, 16'h8001, 16'h0000, 1, 16'h8001, 1'b1, 1'b1, 1'b0, 2, 0);
        run(1, "w16_rcr",   4'd9,  16'h0001, 16'h0000, 1, 16'h8000, 1'b1, 1'b1, 1'b0, 1, 0);

        // Put non-zero state in place, then abort a long shift with reset.
        run(0, "pre_rst", 4'd1, 16'hFF, 16'hFF, 1, 16'hFE, 1'b1, 1'b1, 1'b0, 1, 0);
        seen_done = 1'b0;
        drive(0, 1'b1, 4'd10, 16'h01, 16'h07, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
        seen_done |= done8;
        @(posedge clk); #1;
        seen_done |= done8;
        @(posedge clk); #1;
        seen_done |= done8;
        chk("abort_busy_before_rst", {31'd0, busy8}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_done", {31'd0, seen_done | done8}, 32'd0);
        chk("abort_o", {24'd0, o8}, 32'd0);
        chk("abort_flags", {29'd0, cur_fl(0)}, 32'd0);
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        // Reset wins over a simultaneous start.
        drive(0, 1'b1, 4'd1, 16'h02, 16'h03, 1'b1);
        @(posedge clk); #1;
        chk("rst_prio_ctrl", {30'd0, busy8, done8}, 32'd0);
        chk("rst_prio_o", {24'd0, o8}, 32'd0);
        rst = 1'b0;
        drive(0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
        run(0, "post_rst_add", 4'd1, 16'h02, 16'h03, 1, 16'h05, 1'b0, 1'b0, 1'b0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, datapath width in bits, legal values 4..32.
REQ-002 Parameter: CW, default $clog2(WIDTH), width of the shift-count field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request strobe; sampled only in IDLE.
REQ-006 op  input  4  opcode; sampled with start.
REQ-007 a, b  input  WIDTH each  operands; sampled with start.
REQ-008 fl_we  input  1  update flags at completion when high; sampled with start.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse; o and flags are valid from this cycle.
REQ-011 o  output  WIDTH  registered result; holds until the next done.
REQ-012 fl_carry, fl_lt, fl_z  output  1 each  registered flags.

Function
REQ-013 Opcodes: 0 PASS a; 1 ADD a+b; 2 ADC a+b+fl_carry; 3 SUB a+~b+1; 4 SBC a+~b+fl_carry; 5 NAND ~(a&b); 6 SHL; 7 SHR; 8 RCL; 9 RCR; 10 SHLN; 11 SHRN. Opcodes 12-15 execute as PASS.
REQ-014 Arithmetic is performed at WIDTH+1 bits; the carry is bit WIDTH of the sum, and for SUB/SBC the carry equals 1 when no borrow occurs.
REQ-015 SHL/SHR shift in 0 and carry out the bit shifted off. RCL/RCR shift fl_carry in and carry out the bit shifted off.
REQ-016 For PASS and NAND, carry is 0. lt = o[WIDTH-1]. z = (o == 0).
REQ-017 FSM states: IDLE, SHIFT, DONE. In IDLE, start with op 0-9 or 12-15 -> DONE; start with op 10/11 -> SHIFT, with count loaded from b[CW-1:0].
REQ-018 SHIFT: each cycle, shift the working register by one bit (fill 0, carry = the bit shifted out) and decrement count; when count reaches 0 -> DONE.
REQ-019 SHLN/SHRN with count 0: go to SHIFT for one cycle with no shift, then DONE, and carry = the fl_carry value at start.
REQ-020 DONE lasts one cycle: assert done, load o, load flags if fl_we was captured high, then -> IDLE.
REQ-021 Latency from accepted start to done: 1 cycle for single-cycle ops; count+1 cycles for SHLN/SHRN with count >= 1; 2 cycles for count 0.
REQ-022 start while busy or in DONE is ignored; it is not queued.
REQ-023 Operands are captured at start; changes on a, b, or op during busy have no effect.
REQ-024 ADC/SBC/RCL/RCR use the fl_carry value registered at the cycle of start.
REQ-025 With fl_we low, flags are unchanged while o still updates.

Reset
REQ-026 rst high on any edge forces IDLE, o = 0, fl_carry = fl_lt = fl_z = 0, busy = 0, done = 0, count = 0.
REQ-027 rst asserted mid-operation (SHIFT or DONE) aborts the operation: no done pulse, and o and flags are not updated from it.
REQ-028 rst takes priority over start in the same cycle.

Structure
REQ-029 Shared package alu_pkg holds the opcode enum (OP_PASS..OP_SHRN) and the state typedef (ST_IDLE, ST_SHIFT, ST_DONE).
REQ-030 Sub-module alu_core: purely combinational single-step result and carry/lt/z for all opcodes, parametrised by WIDTH; alu_seq contains the FSM, counter, and registers.

Verification
REQ-031 WIDTH=8, fl_we=1, SUB a=0x05 b=0x05 -> done after 1 cycle, o=0x00, carry=1, z=1, lt=0.
REQ-032 WIDTH=8, ADD 0xFF+0x01, then ADC 0x00+0x00 -> first o=0x00 carry=1 z=1; second o=0x01 carry=0.
REQ-033 WIDTH=8, SHRN a=0x81 b=3 -> busy for 3 cycles, done on 4th, o=0x10, carry=0; start pulses during busy are ignored.
REQ-034 WIDTH=16, SHLN a=0x8001 b=0 -> done on 2nd cycle, o=0x8001, carry = prior fl_carry; then RCR a=0x0001 with fl_carry=1 -> o=0x8000, carry=1.
REQ-035 WIDTH=8, SHLN b=7, rst on 3rd busy cycle -> no done, o=0, flags=0, next start accepted immediately.
REQ-036 fl_we=0, NAND a=0xFF b=0xFF -> o=0x00, flags hold previous values.
